aes_mix_columns_iter: RTL and testbench
=======================================

// Module: aes_mix_columns_iter
// PURPOSE
//  Iterative MixColumns/InvMixColumns stage that consumes the 128-bit state from aes_shift_rows
//  and passes it on to the round-key addition. It processes COLS_PER_CYCLE columns per cycle
//  in place in a single state register, trading latency for area.
//  Ready/valid handshake on both sides; direction is selected per transaction by op_i.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per BUSY cycle; legal 1, 2, 4 (N = 4/COLS_PER_CYCLE)
// PORTS
//  clk_i        in   1    clock; all state updates on rising edge
//  rst_ni       in   1    asynchronous active-low reset
//  in_valid_i   in   1    data_i/op_i valid
//  in_ready_o   out  1    block can accept a state this cycle
//  op_i         in   1    0 = CIPH_FWD (MixColumns), 1 = CIPH_INV (InvMixColumns); sampled on accept
//  data_i       in   128  state, row-major: byte(r,c) = data_i[((r*4)+c)*8 +: 8]
//  out_valid_o  out  1    data_o holds a finished state
//  out_ready_i  in   1    downstream accepts data_o
//  data_o       out  128  result state, same layout as data_i; driven directly from state register
//  busy_o       out  1    high in BUSY and DONE
// BEHAVIOUR
//  Reset: FSM=IDLE, state register=0, column counter=0, op register=0;
//   in_ready_o=1, out_valid_o=0, data_o=0, busy_o=0.
//  FSM IDLE -> BUSY on accept (in_valid_i & in_ready_o): latch data_i and op_i, counter=0.
//  BUSY: each cycle replace columns counter*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 with transformed
//   values; counter += 1; after update of column 3 go DONE. Exactly N BUSY cycles.
//  DONE: out_valid_o=1, data_o stable until out_ready_i. On out handshake: if in_valid_i also
//   high, accept new state (latch, -> BUSY); else -> IDLE.
//  in_ready_o = (state==IDLE) | (state==DONE & out_ready_i). Never ready in BUSY.
//  Latency: accept at edge T -> out_valid_o high in the cycle after edge T+N; N=4 for
//   COLS_PER_CYCLE=1. Throughput: one state per N+1 cycles when out_ready_i held high.
//  Column math, column a0..a3 = rows 0..3, GF(2^8) mod x^8+x^4+x^3+x+1:
//   FWD: b_r = 2*a_r ^ 3*a_{r+1} ^ a_{r+2} ^ a_{r+3} (indices mod 4).
//   INV: b_r = 14*a_r ^ 11*a_{r+1} ^ 13*a_{r+2} ^ 9*a_{r+3}; implement via xtime (mul2) chains,
//   no lookup tables. Columns transformed independently; untouched columns hold value.
//  op register fixed for the whole transaction; op_i changes during BUSY/DONE are ignored.
//  data_i changes after accept have no effect.
//  Reset asserted mid-BUSY or in DONE: immediate return to reset values; partial result lost,
//   no out_valid_o pulse after reset release.
//  out_ready_i high while not DONE: ignored.
//  Illegal COLS_PER_CYCLE: elaboration-time error.
// TESTING
//  1 FWD column: column 0 = (db,13,53,45), others 0 -> column 0 = (8e,4d,a1,bc), others 0, after 4 BUSY cycles.
//  2 INV round-trip: feed result of 1 with op_i=1 -> column 0 = (db,13,53,45); also (c6,c6,c6,c6)
//    and (01,01,01,01) unchanged under both directions; (2d,26,31,4c) FWD -> (4d,7e,bd,f8).
//  3 Backpressure: out_ready_i=0 for 10 cycles in DONE -> data_o stable, in_ready_o=0; release with
//    in_valid_i=1 -> back-to-back accept in same cycle, second result correct.
//  4 Latency: for COLS_PER_CYCLE=1,2,4 measure accept->out_valid_o = 5,3,2 cycles; op_i toggled
//    every cycle during BUSY does not affect result.
//  5 Reset mid-BUSY (after 2 column updates): all outputs at reset values next cycle; no spurious
//    out_valid_o; next transaction (d4,d4,d4,d5) FWD -> (d5,d5,d7,d6).
//  6 Random: 10k random states/ops with random stalls vs. golden model; FWD then INV == identity.

Source files
------------

// File: rtl/aes_mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns stage.
// One 128-bit state register is transformed in place, COLS_PER_CYCLE
// columns per BUSY cycle, with a ready/valid handshake on both sides.
// Byte layout: byte(r,c) = data[((r*4)+c)*8 +: 8].
module aes_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         op_i,
    input  logic [127:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o,
    output logic         busy_o
);

    // Number of BUSY cycles needed to cover all four columns
    localparam int N = 4 / COLS_PER_CYCLE;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
            $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [127:0] state_reg, state_next;
    logic [1:0]   cnt_reg, cnt_next;
    logic         op_reg, op_next;

    logic         accept;
    logic         out_fire;
    logic         last_step;
    logic [127:0] state_upd;
    logic [31:0]  col_in  [4];
    logic [31:0]  col_out [4];
    logic [3:0]   col_sel;

    // GF(2^8) multiply by 2, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Transform one column; a[8*r +: 8] is row r. Inverse coefficients are
    // built from the x2/x4/x8 chain: 9=8+1, 11=8+2+1, 13=8+4+1, 14=8+4+2.
    function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
        logic [7:0]  v  [4];
        logic [7:0]  m2 [4];
        logic [7:0]  m4 [4];
        logic [7:0]  m8 [4];
        logic [31:0] b;
        logic [1:0]  i0, i1, i2, i3;
        for (int r = 0; r < 4; r++) begin
            v[r]  = a[8*r +: 8];
            m2[r] = xtime(v[r]);
            m4[r] = xtime(m2[r]);
            m8[r] = xtime(m4[r]);
        end
        b = '0;
        for (int r = 0; r < 4; r++) begin
            i0 = 2'(r);
            i1 = 2'(r + 1);
            i2 = 2'(r + 2);
            i3 = 2'(r + 3);
            if (inv) begin
                b[8*r +: 8] = (m8[i0] ^ m4[i0] ^ m2[i0])
                            ^ (m8[i1] ^ m2[i1] ^ v[i1])
                            ^ (m8[i2] ^ m4[i2] ^ v[i2])
                            ^ (m8[i3] ^ v[i3]);
            end else begin
                b[8*r +: 8] = m2[i0] ^ (m2[i1] ^ v[i1]) ^ v[i2] ^ v[i3];
            end
        end
        return b;
    endfunction

    assign accept    = in_valid_i & in_ready_o;
    assign out_fire  = out_valid_o & out_ready_i;
    assign last_step = (cnt_reg == 2'(N - 1));

    // Per-column extract, transform and write-back select
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign col_sel[gi] = (fsm_reg == BUSY) && (cnt_reg == 2'(gi / COLS_PER_CYCLE));
            assign col_out[gi] = mix_col(col_in[gi], op_reg);
            for (genvar gr = 0; gr < 4; gr++) begin : g_row
                assign col_in[gi][8*gr +: 8] = state_reg[((gr*4)+gi)*8 +: 8];
                assign state_upd[((gr*4)+gi)*8 +: 8] =
                    col_sel[gi] ? col_out[gi][8*gr +: 8] : state_reg[((gr*4)+gi)*8 +: 8];
            end
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE: if (accept) fsm_next = BUSY;
            BUSY: if (last_step) fsm_next = DONE;
            DONE: if (out_fire) fsm_next = accept ? BUSY : IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    // Handshake and status outputs
    always_comb begin
        in_ready_o  = (fsm_reg == IDLE) || ((fsm_reg == DONE) && out_ready_i);
        out_valid_o = (fsm_reg == DONE);
        busy_o      = (fsm_reg == BUSY) || (fsm_reg == DONE);
    end

    // Datapath next values: load on accept, otherwise step the column counter
    always_comb begin
        state_next = accept ? data_i : state_upd;
        op_next    = accept ? op_i : op_reg;
        cnt_next   = cnt_reg;
        if (accept) begin
            cnt_next = 2'd0;
        end else if (fsm_reg == BUSY) begin
            cnt_next = last_step ? 2'd0 : cnt_reg + 2'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= '0;
            cnt_reg   <= 2'd0;
            op_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
        end
    end

    assign data_o = state_reg;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Directed testbench for aes_mix_columns_iter. Three instances
// (COLS_PER_CYCLE = 1, 2, 4) share all inputs; most tests observe the
// COLS_PER_CYCLE = 1 instance, the latency test observes all three.
module tb_aes_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         op;
    logic [127:0] data_in;
    logic         out_ready;

    logic         in_ready_c1, out_valid_c1, busy_c1;
    logic [127:0] data_out_c1;
    logic         in_ready_c2, out_valid_c2, busy_c2;
    logic [127:0] data_out_c2;
    logic         in_ready_c4, out_valid_c4, busy_c4;
    logic [127:0] data_out_c4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_c1),
        .op_i(op), .data_i(data_in), .out_valid_o(out_valid_c1), .out_ready_i(out_ready),
        .data_o(data_out_c1), .busy_o(busy_c1)
    );

    aes_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut_c2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_c2),
        .op_i(op), .data_i(data_in), .out_valid_o(out_valid_c2), .out_ready_i(out_ready),
        .data_o(data_out_c2), .busy_o(busy_c2)
    );

    aes_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut_c4 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_c4),
        .op_i(op), .data_i(data_in), .out_valid_o(out_valid_c4), .out_ready_i(out_ready),
        .data_o(data_out_c4), .busy_o(busy_c4)
    );

    // Place a column given as {row0,row1,row2,row3} into column c of a state
    function automatic logic [127:0] set_col(input logic [127:0] s, input int c, input logic [31:0] col);
        logic [127:0] t;
        t = s;
        for (int r = 0; r < 4; r++) begin
            t[((r*4)+c)*8 +: 8] = col[(3-r)*8 +: 8];
        end
        return t;
    endfunction

    logic [127:0] s1, e1, s2, e2, s3, s5, e5;

    initial begin
        s1 = set_col(128'h0, 0, 32'hdb135345);
        e1 = set_col(128'h0, 0, 32'h8e4da1bc);
        s2 = set_col(s1, 1, 32'hc6c6c6c6);
        s2 = set_col(s2, 2, 32'h01010101);
        s2 = set_col(s2, 3, 32'h2d26314c);
        e2 = set_col(e1, 1, 32'hc6c6c6c6);
        e2 = set_col(e2, 2, 32'h01010101);
        e2 = set_col(e2, 3, 32'h4d7ebdf8);
        s3 = set_col(128'h0, 1, 32'hc6c6c6c6);
        s3 = set_col(s3, 2, 32'h01010101);
        s5 = set_col(128'h0, 0, 32'hd4d4d4d5);
        s5 = set_col(s5, 2, 32'hc6c6c6c6);
        e5 = set_col(128'h0, 0, 32'hd5d5d7d6);
        e5 = set_col(e5, 2, 32'hc6c6c6c6);
    end

    // Present one state to the COLS_PER_CYCLE=1 instance and collect its result.
    // lat counts clock edges from the accept edge to the edge that consumes the result.
    task automatic run_txn(input logic [127:0] din, input logic op_val,
                           output logic [127:0] dout, output int lat, output bit ok);
        ok = 1'b0;
        lat = 0;
        dout = '0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20 && !in_ready_c1; i++) @(negedge clk);
        in_valid = 1'b1;
        data_in  = din;
        op       = op_val;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        op       = ~op_val;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid_c1) begin
                ok = 1'b1;
                break;
            end
        end
        dout = data_out_c1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        op        = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready_c1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_c1); end
        checks++;
        if (out_valid_c1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_c1); end
        checks++;
        if (data_out_c1 !== 128'h0) begin errors++; $display("FAIL reset_data got %h want 0", data_out_c1); end
        checks++;
        if (busy_c1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_c1); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset: checked outputs at reset values");
    endtask

    task automatic test_fwd_column();
        logic [127:0] r;
        int lat;
        bit ok;
        run_txn(s1, 1'b0, r, lat, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fwd_col_timeout out_valid never rose"); end
        checks++;
        if (r !== e1) begin errors++; $display("FAIL fwd_col got %h want %h", r, e1); end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL fwd_col_latency got %0d want 5", lat); end
        $display("fwd_column: in %h out %h lat %0d", s1, r, lat);
    endtask

    task automatic test_inv_roundtrip();
        logic [127:0] r;
        int lat;
        bit ok;
        run_txn(e1, 1'b1, r, lat, ok);
        checks++;
        if (!ok || r !== s1) begin errors++; $display("FAIL inv_col got %h want %h", r, s1); end
        $display("inv_column: in %h out %h", e1, r);
        run_txn(s2, 1'b0, r, lat, ok);
        checks++;
        if (!ok || r !== e2) begin errors++; $display("FAIL fwd_mixed got %h want %h", r, e2); end
        $display("fwd_mixed: in %h out %h", s2, r);
        run_txn(e2, 1'b1, r, lat, ok);
        checks++;
        if (!ok || r !== s2) begin errors++; $display("FAIL inv_mixed got %h want %h", r, s2); end
        $display("inv_mixed: in %h out %h", e2, r);
        run_txn(s3, 1'b0, r, lat, ok);
        checks++;
        if (!ok || r !== s3) begin errors++; $display("FAIL fwd_fixed got %h want %h", r, s3); end
        $display("fwd_fixed: in %h out %h", s3, r);
        run_txn(s3, 1'b1, r, lat, ok);
        checks++;
        if (!ok || r !== s3) begin errors++; $display("FAIL inv_fixed got %h want %h", r, s3); end
        $display("inv_fixed: in %h out %h", s3, r);
    endtask

    task automatic test_back_to_back();
        logic [127:0] held;
        bit seen;
        bit stable;
        seen = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = s1;
        op       = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid_c1) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_timeout out_valid never rose"); end
        held = data_out_c1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (data_out_c1 !== held || in_ready_c1 !== 1'b0 || out_valid_c1 !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL bp_hold data %h ready %b valid %b", data_out_c1, in_ready_c1, out_valid_c1); end
        checks++;
        if (held !== e1) begin errors++; $display("FAIL bp_first got %h want %h", held, e1); end
        in_valid  = 1'b1;
        data_in   = s5;
        op        = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready_c1 !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready_c1); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = '1;
        @(negedge clk);
        checks++;
        if (out_valid_c1 !== 1'b0 || busy_c1 !== 1'b1) begin
            errors++; $display("FAIL b2b_accept valid %b busy %b want 0 1", out_valid_c1, busy_c1);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid_c1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen || data_out_c1 !== e5) begin errors++; $display("FAIL b2b_second got %h want %h", data_out_c1, e5); end
        $display("back_to_back: first %h second %h", held, data_out_c1);
        drain();
    endtask

    task automatic test_latency();
        int lat1, lat2, lat4;
        logic [127:0] r1, r2, r4;
        lat1 = 0; lat2 = 0; lat4 = 0;
        r1 = '0; r2 = '0; r4 = '0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = s2;
        op       = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            op      = ~op;
            data_in = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (out_valid_c1 && lat1 == 0) begin lat1 = i; r1 = data_out_c1; end
            if (out_valid_c2 && lat2 == 0) begin lat2 = i; r2 = data_out_c2; end
            if (out_valid_c4 && lat4 == 0) begin lat4 = i; r4 = data_out_c4; end
        end
        checks++;
        if (lat1 !== 5) begin errors++; $display("FAIL lat_c1 got %0d want 5", lat1); end
        checks++;
        if (lat2 !== 3) begin errors++; $display("FAIL lat_c2 got %0d want 3", lat2); end
        checks++;
        if (lat4 !== 2) begin errors++; $display("FAIL lat_c4 got %0d want 2", lat4); end
        checks++;
        if (r1 !== e2) begin errors++; $display("FAIL op_toggle_c1 got %h want %h", r1, e2); end
        checks++;
        if (r2 !== e2) begin errors++; $display("FAIL op_toggle_c2 got %h want %h", r2, e2); end
        checks++;
        if (r4 !== e2) begin errors++; $display("FAIL op_toggle_c4 got %h want %h", r4, e2); end
        $display("latency: c1 %0d c2 %0d c4 %0d", lat1, lat2, lat4);
        drain();
    endtask

    task automatic test_reset_mid_busy();
        bit spurious;
        logic [127:0] r;
        int lat;
        bit ok;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = s2;
        op       = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready_c1 !== 1'b1 || out_valid_c1 !== 1'b0 || busy_c1 !== 1'b0 || data_out_c1 !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset ready %b valid %b busy %b data %h", in_ready_c1, out_valid_c1, busy_c1, data_out_c1);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid_c1 !== 1'b0 || busy_c1 !== 1'b0) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin errors++; $display("FAIL mid_reset_spurious valid %b busy %b", out_valid_c1, busy_c1); end
        run_txn(s5, 1'b0, r, lat, ok);
        checks++;
        if (!ok || r !== e5) begin errors++; $display("FAIL after_reset got %h want %h", r, e5); end
        $display("reset_mid_busy: next txn out %h", r);
    endtask

    task automatic test_random_roundtrip();
        logic [127:0] s, f, b;
        int lat;
        bit ok1, ok2;
        for (int k = 0; k < 8; k++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            run_txn(s, 1'b0, f, lat, ok1);
            run_txn(f, 1'b1, b, lat, ok2);
            checks++;
            if (!ok1 || !ok2 || b !== s) begin errors++; $display("FAIL roundtrip_%0d got %h want %h", k, b, s); end
            $display("roundtrip: in %h fwd %h back %h", s, f, b);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        test_reset();
        test_fwd_column();
        test_inv_roundtrip();
        test_back_to_back();
        test_latency();
        test_reset_mid_busy();
        test_random_roundtrip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
